// File: rtl/split_inst_data_ram_if.sv
// split_inst_data_ram_if: strobes, addresses and data of the split instruction/data memory.
//   master drives strobes, addresses and write data; slave returns registered read data.
interface split_inst_data_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 16
);
  logic                  Ram_Data_Read;
  logic                  Ram_Data_Write;
  logic                  Ram_Inst_Read;
  logic                  Ram_Inst_Write;
  logic [ADDR_WIDTH-1:0] Ram_Addr;
  logic [ADDR_WIDTH-1:0] Inst_Addr;
  logic [DATA_WIDTH-1:0] Ram_Data_In;
  logic [INST_WIDTH-1:0] Ram_Inst_In;
  logic [DATA_WIDTH-1:0] Ram_Data_Out;
  logic [INST_WIDTH-1:0] Ram_Inst_Out;
  modport master (
    output Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Ram_Inst_Write,
    output Ram_Addr, Inst_Addr, Ram_Data_In, Ram_Inst_In,
    input  Ram_Data_Out, Ram_Inst_Out
  );
  modport slave (
    input  Ram_Data_Read, Ram_Data_Write, Ram_Inst_Read, Ram_Inst_Write,
    input  Ram_Addr, Inst_Addr, Ram_Data_In, Ram_Inst_In,
    output Ram_Data_Out, Ram_Inst_Out
  );
endinterface

// File: rtl/split_inst_data_ram.sv
// split_inst_data_ram: main memory with independent instruction and data arrays.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset, clears both arrays and both outputs
//   bus   : slave side of split_inst_data_ram_if (strobes, addresses, write data,
//           registered read data with one-cycle latency, write-first on collision)
module split_inst_data_ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int INST_WIDTH   = 16,
  parameter int NUM_MEM_ADDR = 256
) (
  input logic                  Clk,
  input logic                  Rst_n,
  split_inst_data_ram_if.slave bus
);
  localparam logic [31:0] NUM_U = NUM_MEM_ADDR;
  logic [DATA_WIDTH-1:0] data_mem_q [NUM_MEM_ADDR];
  logic [INST_WIDTH-1:0] inst_mem_q [NUM_MEM_ADDR];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic                  data_ok, inst_ok, data_we, inst_we;
  always_comb begin
    data_ok    = 32'(bus.Ram_Addr) < NUM_U;
    inst_ok    = 32'(bus.Inst_Addr) < NUM_U;
    data_we    = bus.Ram_Data_Write && data_ok;
    inst_we    = bus.Ram_Inst_Write && inst_ok;
    // a simultaneous write to the read address is forwarded (write-first)
    data_out_d = !bus.Ram_Data_Read ? data_out_q :
                 !data_ok ? '0 :
                 data_we ? bus.Ram_Data_In : data_mem_q[bus.Ram_Addr];
    inst_out_d = !bus.Ram_Inst_Read ? inst_out_q :
                 !inst_ok ? '0 :
                 inst_we ? bus.Ram_Inst_In : inst_mem_q[bus.Inst_Addr];
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out_q <= '0;
      inst_out_q <= '0;
      for (int i = 0; i < NUM_MEM_ADDR; i++) begin
        data_mem_q[i] <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      inst_out_q <= inst_out_d;
      if (data_we) data_mem_q[bus.Ram_Addr] <= bus.Ram_Data_In;
      if (inst_we) inst_mem_q[bus.Inst_Addr] <= bus.Ram_Inst_In;
    end
  end
  assign bus.Ram_Data_Out = data_out_q;
  assign bus.Ram_Inst_Out = inst_out_q;
endmodule

// File: tb/tb_split_inst_data_ram.sv
// tb_split_inst_data_ram: directed and random checks of split_inst_data_ram.
module tb_split_inst_data_ram;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0]  dm [256];
  logic [15:0] im [256];
  logic [7:0]  exp_d;
  logic [15:0] exp_i;
  split_inst_data_ram_if bus ();
  split_inst_data_ram dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic dr, input logic dw, input logic ir, input logic iw,
                       input logic [7:0] ra, input logic [7:0] ia,
                       input logic [7:0] di, input logic [15:0] ii);
    bus.Ram_Data_Read  = dr;
    bus.Ram_Data_Write = dw;
    bus.Ram_Inst_Read  = ir;
    bus.Ram_Inst_Write = iw;
    bus.Ram_Addr       = ra;
    bus.Inst_Addr      = ia;
    bus.Ram_Data_In    = di;
    bus.Ram_Inst_In    = ii;
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12 Rst_n = 1'b1;
    tick();
    check("reset_data", {8'h0, bus.Ram_Data_Out}, 16'h0);
    check("reset_inst", bus.Ram_Inst_Out, 16'h0);
    // preload address 5 and read it so both outputs are nonzero
    drive(0, 1, 0, 1, 8'd5, 8'd5, 8'hAA, 16'hBEEF);
    tick();
    drive(1, 0, 1, 0, 8'd5, 8'd5, 8'h00, 16'h0000);
    tick();
    check("preload_data", {8'h0, bus.Ram_Data_Out}, 16'h00AA);
    check("preload_inst", bus.Ram_Inst_Out, 16'hBEEF);
    // asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("async_rst_data", {8'h0, bus.Ram_Data_Out}, 16'h0);
    check("async_rst_inst", bus.Ram_Inst_Out, 16'h0);
    #2 Rst_n = 1'b1;
    drive(1, 0, 1, 0, 8'd5, 8'd5, 8'h00, 16'h0000);
    tick();
    check("post_rst_data5", {8'h0, bus.Ram_Data_Out}, 16'h0);
    check("post_rst_inst5", bus.Ram_Inst_Out, 16'h0);
    // sequential fill: write then read each address
    for (int a = 0; a < 256; a++) begin
      drive(0, 1, 0, 1, 8'(a), 8'(a), 8'(a), 16'(a) ^ 16'hA5A5);
      tick();
      drive(1, 0, 1, 0, 8'(a), 8'(a), 8'h00, 16'h0000);
      tick();
      check("fill_data", {8'h0, bus.Ram_Data_Out}, {8'h0, 8'(a)});
      check("fill_inst", bus.Ram_Inst_Out, 16'(a) ^ 16'hA5A5);
    end
    // independence
    drive(0, 1, 0, 1, 8'd3, 8'd3, 8'h56, 16'h1234);
    tick();
    drive(0, 1, 0, 0, 8'd3, 8'd3, 8'h77, 16'hFFFF);
    tick();
    drive(1, 0, 1, 0, 8'd3, 8'd3, 8'h00, 16'h0000);
    tick();
    check("indep_inst", bus.Ram_Inst_Out, 16'h1234);
    check("indep_data", {8'h0, bus.Ram_Data_Out}, 16'h0077);
    // hold: drop read, move address
    drive(0, 0, 0, 0, 8'd0, 8'd0, 8'h00, 16'h0000);
    tick();
    tick();
    check("hold_data", {8'h0, bus.Ram_Data_Out}, 16'h0077);
    check("hold_inst", bus.Ram_Inst_Out, 16'h1234);
    // read-during-write, write-first on both paths
    drive(1, 1, 1, 1, 8'd10, 8'd20, 8'h3C, 16'hC0DE);
    tick();
    check("rdw_data", {8'h0, bus.Ram_Data_Out}, 16'h003C);
    check("rdw_inst", bus.Ram_Inst_Out, 16'hC0DE);
    // strobes held high: one access per cycle, different addresses per path
    drive(1, 0, 1, 0, 8'd10, 8'd7, 8'h00, 16'h0000);
    tick();
    check("held_data10", {8'h0, bus.Ram_Data_Out}, 16'h003C);
    check("held_inst7", bus.Ram_Inst_Out, 16'h0007 ^ 16'hA5A5);
    bus.Ram_Addr  = 8'd200;
    bus.Inst_Addr = 8'd20;
    tick();
    check("held_data200", {8'h0, bus.Ram_Data_Out}, 16'h00C8);
    check("held_inst20", bus.Ram_Inst_Out, 16'hC0DE);
    // random against a reference model built from the known contents
    for (int a = 0; a < 256; a++) begin
      dm[a] = 8'(a);
      im[a] = 16'(a) ^ 16'hA5A5;
    end
    dm[3] = 8'h77; im[3] = 16'h1234;
    dm[10] = 8'h3C; im[20] = 16'hC0DE;
    exp_d = 8'hC8;
    exp_i = 16'hC0DE;
    for (int n = 0; n < 100; n++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            8'($urandom), 16'($urandom));
      if (bus.Ram_Data_Write) dm[bus.Ram_Addr] = bus.Ram_Data_In;
      if (bus.Ram_Inst_Write) im[bus.Inst_Addr] = bus.Ram_Inst_In;
      if (bus.Ram_Data_Read) exp_d = dm[bus.Ram_Addr];
      if (bus.Ram_Inst_Read) exp_i = im[bus.Inst_Addr];
      tick();
      check("rand_data", {8'h0, bus.Ram_Data_Out}, {8'h0, exp_d});
      check("rand_inst", bus.Ram_Inst_Out, exp_i);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
